// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit.
// Optional build macro: IFETCH_BSWAP_EN (big-endian ROM image).
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifetch_state_e;

    localparam int IFQ_DEPTH = 4;
    localparam int IFQ_CNT_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Four-entry fetch queue holding {pc, inst} pairs.
// Flush wins over push and pop in the same cycle.
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  ifq_entry_t           push_data,
    input  logic                 pop,
    output ifq_entry_t           head,
    output logic [IFQ_CNT_W-1:0] count
);

    ifq_entry_t           mem_q [IFQ_DEPTH];
    ifq_entry_t           mem_d [IFQ_DEPTH];
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [IFQ_CNT_W-1:0] count_q, count_d;
    logic                 do_push, do_pop;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != IFQ_CNT_W'(IFQ_DEPTH));
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b0, do_push} - {2'b0, do_pop};
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale slots are never visible, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: drives a registered ROM, queues responses.
// Define IFETCH_BSWAP_EN to byte-swap big-endian ROM words.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        fault
);

    ifetch_state_e        state_q, state_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic                 inflight_q, inflight_d;
    logic [31:0]          inflight_pc_q, inflight_pc_d;
    logic [29:0]          rom_addr_q, rom_addr_d;
    logic                 fault_q, fault_d;

    logic [IFQ_CNT_W-1:0] fifo_count;
    ifq_entry_t           fifo_head;
    ifq_entry_t           cap_entry;
    logic                 redir, redir_ok, room;
    logic                 q_flush, q_push, q_pop;
    logic [3:0]           occ;

    // Response word as it enters the queue.
    always_comb begin
        cap_entry.pc = inflight_pc_q;
`ifdef IFETCH_BSWAP_EN
        cap_entry.inst = bswap32(rom_inst);
`else
        cap_entry.inst = rom_inst;
`endif
    end

    // Issue, redirect and FSM next-state decisions.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rom_addr_d    = rom_addr_q;
        fault_d       = fault_q;
        redir    = redirect_valid && (state_q == RUN);
        redir_ok = redir && (redirect_pc[1:0] == 2'b00);
        occ      = {1'b0, fifo_count} + {3'b0, inflight_q};
        room     = occ < 4'd4;
        q_flush  = redir;
        q_push   = inflight_q && !redir;
        q_pop    = out_valid && out_ready;
        if (redir) begin
            if (redir_ok) begin
                rom_addr_d    = redirect_pc[31:2];
                inflight_d    = 1'b1;
                inflight_pc_d = {redirect_pc[31:2], 2'b00};
                fetch_pc_d    = redirect_pc + 32'd4;
            end else begin
                state_d = HALT;
                fault_d = 1'b1;
            end
        end else if (state_q != HALT && room) begin
            rom_addr_d    = fetch_pc_q[31:2];
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            if (state_q == BOOT) begin
                state_d = RUN;
            end
        end
    end

    // FSM and fetch bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            rom_addr_q    <= RESET_PC[31:2];
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rom_addr_q    <= rom_addr_d;
            fault_q       <= fault_d;
        end
    end

    ifetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (cap_entry),
        .pop       (q_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign rom_addr  = rst ? rom_addr_d : RESET_PC[31:2];
    assign out_valid = fifo_count != '0;
    assign out_pc    = out_valid ? fifo_head.pc : 32'h0;
    assign out_inst  = out_valid ? fifo_head.inst : 32'h0;
    assign fault     = fault_q;

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch with a queue-level reference model.
// Build with or without IFETCH_BSWAP_EN.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] rom_addr;
    logic [31:0] rom_inst = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        fault;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .fault          (fault)
    );

    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'd0:   return 32'h37070010;
            30'd1:   return 32'h13070760;
            30'd2:   return 32'hef004000;
            30'h37:  return 32'h67800000;
            default: return ({2'b0, a} * 32'h9E3779B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [31:0] w;
        w = rom_word(pc[31:2]);
`ifdef IFETCH_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Instruction ROM: registers the address, data next cycle.
    always @(posedge clk) rom_inst <= rom_word(rom_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: delivered stream, pending response, fetch PC.
    logic [31:0] mq[$];
    int          pend_v = 0;
    logic [31:0] pend_pc = 32'h0;
    logic [31:0] fpc = RST_PC;
    logic [29:0] last_a = RST_PC[31:2];
    int          mst = 0;
    bit          mfault = 1'b0;
    bit          mv = 1'b0;

    always @(negedge clk) begin
        logic [29:0] ea;
        int          occ;
        bit          iss;
        occ = mq.size() + pend_v;
        ea  = last_a;
        iss = 1'b0;
        if (!rst) begin
            ea = RST_PC[31:2];
        end else if (mst == 1 && redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) ea = redirect_pc[31:2];
        end else if (mst != 2 && occ < 4) begin
            ea  = fpc[31:2];
            iss = 1'b1;
        end
        if (mv) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
            chk("out_pc", out_pc, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("out_inst", out_inst,
                (mq.size() != 0) ? exp_inst(mq[0]) : 32'h0);
            chk("rom_addr", {2'b0, rom_addr}, {2'b0, ea});
            chk("fault", {31'b0, fault}, {31'b0, mfault});
        end
        if (!rst) begin
            mq.delete();
            pend_v = 0;
            fpc    = RST_PC;
            last_a = RST_PC[31:2];
            mst    = 0;
            mfault = 1'b0;
            mv     = 1'b1;
        end else if (mv) begin
            if (mst == 1 && redirect_valid) begin
                mq.delete();
                pend_v = 0;
                if (redirect_pc[1:0] == 2'b00) begin
                    pend_v  = 1;
                    pend_pc = redirect_pc;
                    fpc     = redirect_pc + 32'd4;
                    last_a  = ea;
                end else begin
                    mst    = 2;
                    mfault = 1'b1;
                end
            end else begin
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (pend_v != 0) mq.push_back(pend_pc);
                pend_v = 0;
                if (iss) begin
                    pend_v  = 1;
                    pend_pc = fpc;
                    fpc     = fpc + 32'd4;
                    last_a  = ea;
                end
                if (mst == 0) mst = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          issues;
        logic [29:0] naddr;
        logic [29:0] hold;
        bit          got;
        int          r;
        logic [31:0] rp;

        // Boot latency and byte order.
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #3 chk("boot_rom_addr", {2'b0, rom_addr}, RST_PC >> 2);
        tick();
        #3 chk("c1_valid", {31'b0, out_valid}, 32'd0);
        tick();
        #3;
        chk("c2_valid", {31'b0, out_valid}, 32'd1);
        chk("c2_pc", out_pc, 32'h0);
`ifdef IFETCH_BSWAP_EN
        chk("c2_inst", out_inst, 32'h10000737);
`else
        chk("c2_inst", out_inst, 32'h37070010);
`endif
        tick();
        #3;
        chk("c3_pc", out_pc, 32'h4);
`ifdef IFETCH_BSWAP_EN
        chk("c3_inst", out_inst, 32'h60070713);
`else
        chk("c3_inst", out_inst, 32'h13070760);
`endif
        tick();

        // Stall ten cycles from boot, then drain.
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        issues = 0;
        naddr = '0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (rom_addr == naddr) begin
                issues++;
                naddr++;
            end
            tick();
        end
        chk("stall_issues", issues, 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_pc", out_pc, 32'(k * 4));
            if (k == 2) begin
`ifdef IFETCH_BSWAP_EN
                chk("word2_inst", out_inst, 32'h004000ef);
`else
                chk("word2_inst", out_inst, 32'hef004000);
`endif
            end
            tick();
        end

        // Aligned redirect coinciding with a pop.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_00DC;
        #3 chk("redir_rom_addr", {2'b0, rom_addr}, 32'h37);
        tick();
        redirect_valid = 1'b0;
        #3 chk("redir_gap", {31'b0, out_valid}, 32'd0);
        tick();
        #3;
        chk("redir_pc", out_pc, 32'hDC);
`ifdef IFETCH_BSWAP_EN
        chk("redir_inst", out_inst, 32'h00008067);
`else
        chk("redir_inst", out_inst, 32'h67800000);
`endif
        tick();

        // Misaligned redirect halts the unit.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0006;
        #3 hold = rom_addr;
        tick();
        redirect_valid = 1'b0;
        #3 chk("fault_set", {31'b0, fault}, 32'd1);
        tick();
        for (int i = 0; i < 20; i++) begin
            #3;
            chk("halt_valid", {31'b0, out_valid}, 32'd0);
            chk("halt_rom_addr", {2'b0, rom_addr}, {2'b0, hold});
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        #3 chk("halt_redir_addr", {2'b0, rom_addr}, {2'b0, hold});
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3 chk("halt_redir_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end

        // Reset pulse with a full queue.
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        #3 chk("full_valid", {31'b0, out_valid}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #3;
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_fault", {31'b0, fault}, 32'd0);
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            #3;
            if (out_valid) got = 1'b1;
        end
        chk("post_rst_seen", {31'b0, got}, 32'd1);
        chk("post_rst_pc", out_pc, RST_PC);
        tick();

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            out_ready = ($urandom % 10) < 7;
            redirect_valid = 1'b0;
            rst = 1'b1;
            r = int'($urandom % 1000);
            if (r < 25) begin
                redirect_valid = 1'b1;
                if ($urandom % 4 == 0) redirect_pc = 32'hFFFF_FFF0;
                else redirect_pc = $urandom_range(0, 4095) << 2;
            end else if (r < 28) begin
                rp = $urandom;
                if (rp[1:0] == 2'b00) rp[0] = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc = rp;
            end else if (r < 36) begin
                rst = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
